// File: rtl/hex_display_pkg.sv
// Shared constants for the hex_display controller: the active-high glyph table,
// the "all segments off" code and the supported digit-count limit.
package hex_display_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'b000_0000;

  // Entry n is the gfedcba pattern for nibble n, segment on = 1.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  function automatic logic [6:0] glyph_of(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hex_glyph.sv
// Combinational nibble to gfedcba lookup, active-high; an unlit digit returns SEG_OFF.
module hex_glyph
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       lit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (lit) seg = glyph_of(nibble);
  end

endmodule

// File: rtl/hex_display.sv
// Multi-digit hex seven-segment controller with static and multiplexed outputs.
// Optional leading-zero blanking is built when HEX_DISPLAY_LZB_EN is defined.
module hex_display
  import hex_display_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_LOG2 = 24,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     ena,
  input  logic [DIGITS-1:0]     blink,
  output logic [7*DIGITS-1:0]   seg_all,
  output logic [DIGITS-1:0]     dp_all,
  output logic [7:0]            scan_seg,
  output logic [DIGITS-1:0]     scan_an
);

  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic               POL        = ACTIVE_LOW;

  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   ena_q, ena_d;
  logic [DIGITS-1:0]   blink_q, blink_d;

  logic [BLINK_LOG2-1:0] blink_cnt_q, blink_cnt_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic [7*DIGITS-1:0] seg_all_q, seg_all_d;
  logic [DIGITS-1:0]   dp_all_q, dp_all_d;
  logic [7:0]          scan_seg_q, scan_seg_d;
  logic [DIGITS-1:0]   scan_an_q, scan_an_d;

  logic                blink_off;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   lit;
  logic [7*DIGITS-1:0] seg_hi;
  logic [3:0]          sel_nibble;
  logic                sel_dp;
  logic                sel_lit;
  logic [DIGITS-1:0]   an_onehot;
  logic [6:0]          scan_glyph;
  logic                guard;

  always_comb begin
    value_d = value_q;
    dp_d    = dp_q;
    ena_d   = ena_q;
    blink_d = blink_q;
    if (load) begin
      value_d = value;
      dp_d    = dp;
      ena_d   = ena;
      blink_d = blink;
    end
  end

  assign blink_cnt_d = blink_cnt_q + BLINK_LOG2'(1);
  assign blink_off   = blink_cnt_q[BLINK_LOG2-1];

  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

`ifdef HEX_DISPLAY_LZB_EN
  // Walk down from the top digit; the first enabled nonzero or dp digit ends the run.
  logic lzb_run;
  always_comb begin
    blank   = '0;
    lzb_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (ena_q[k] && ((value_q[4*k +: 4] != 4'h0) || dp_q[k])) lzb_run = 1'b0;
      blank[k] = lzb_run && ena_q[k];
    end
  end
`else
  assign blank = '0;
`endif

  assign lit = ena_q & ~(blink_q & {DIGITS{blink_off}}) & ~blank;

  for (genvar g = 0; g < DIGITS; g++) begin : g_static
    hex_glyph u_glyph (
      .nibble (value_q[4*g +: 4]),
      .lit    (lit[g]),
      .seg    (seg_hi[7*g +: 7])
    );
  end

  always_comb begin
    sel_nibble = '0;
    sel_dp     = 1'b0;
    sel_lit    = 1'b0;
    an_onehot  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_nibble   = value_q[4*k +: 4];
        sel_dp       = dp_q[k];
        sel_lit      = lit[k];
        an_onehot[k] = 1'b1;
      end
    end
  end

  hex_glyph u_scan_glyph (
    .nibble (sel_nibble),
    .lit    (sel_lit),
    .seg    (scan_glyph)
  );

  // First prescaler count of a slot is the dead time after an index change.
  assign guard = (presc_q == '0);

  always_comb begin
    seg_all_d = seg_hi ^ {(7*DIGITS){POL}};
    dp_all_d  = (dp_q & lit) ^ {DIGITS{POL}};
    if (guard) begin
      scan_seg_d = {8{POL}};
      scan_an_d  = {DIGITS{POL}};
    end else begin
      scan_seg_d = {sel_dp & sel_lit, scan_glyph} ^ {8{POL}};
      scan_an_d  = an_onehot ^ {DIGITS{POL}};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value_q     <= '0;
      dp_q        <= '0;
      ena_q       <= '0;
      blink_q     <= '0;
      blink_cnt_q <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      seg_all_q   <= {(7*DIGITS){POL}};
      dp_all_q    <= {DIGITS{POL}};
      scan_seg_q  <= {8{POL}};
      scan_an_q   <= {DIGITS{POL}};
    end else begin
      value_q     <= value_d;
      dp_q        <= dp_d;
      ena_q       <= ena_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      seg_all_q   <= seg_all_d;
      dp_all_q    <= dp_all_d;
      scan_seg_q  <= scan_seg_d;
      scan_an_q   <= scan_an_d;
    end
  end

  assign seg_all  = seg_all_q;
  assign dp_all   = dp_all_q;
  assign scan_seg = scan_seg_q;
  assign scan_an  = scan_an_q;

endmodule

// File: tb/tb_hex_display.sv
// Directed bench for hex_display: 4 digits, 4-clock scan slots, 8-clock blink period, active-low.
module tb_hex_display;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  ena = '0;
  logic [3:0]  blink = '0;
  logic [27:0] seg_all;
  logic [3:0]  dp_all;
  logic [7:0]  scan_seg;
  logic [3:0]  scan_an;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [3:0]  an_tab  [4];
  logic [7:0]  sseg_tab[4];
  logic [27:0] exp_seg;
  logic [3:0]  exp_an;
  logic [7:0]  exp_sseg;

  hex_display #(
    .DIGITS     (4),
    .SCAN_DIV   (4),
    .BLINK_LOG2 (3),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load),
    .value    (value),
    .dp       (dp),
    .ena      (ena),
    .blink    (blink),
    .seg_all  (seg_all),
    .dp_all   (dp_all),
    .scan_seg (scan_seg),
    .scan_an  (scan_an)
  );

  always #5 clock = ~clock;

  // Edges seen since reset release; used to place blink and scan phases.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e,
                         input logic [3:0] b);
    value = v;
    dp    = d;
    ena   = e;
    blink = b;
    load  = 1'b1;
    @(negedge clock);
    load  = 1'b0;
  endtask

  initial begin
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
    // 12AF with dp on digit 1: F, A., 2, 1 as {dp, gfedcba} active-low
    sseg_tab[0] = 8'h8E; sseg_tab[1] = 8'h08; sseg_tab[2] = 8'hA4; sseg_tab[3] = 8'hF9;

    repeat (3) @(negedge clock);
    check_eq("rst_seg_all",  seg_all,  28'hFFFFFFF);
    check_eq("rst_dp_all",   dp_all,   4'hF);
    check_eq("rst_scan_seg", scan_seg, 8'hFF);
    check_eq("rst_scan_an",  scan_an,  4'hF);

    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("dark_after_rst", seg_all, 28'hFFFFFFF);

    do_load(16'h12AF, 4'h0, 4'hF, 4'h0);
    check_eq("load_latency", seg_all, 28'hFFFFFFF);
    @(negedge clock);
    check_eq("glyph_12AF", seg_all, {7'h79, 7'h24, 7'h08, 7'h0E});
    check_eq("dp_12AF",    dp_all,  4'hF);

    do_load(16'h8888, 4'h0, 4'b0101, 4'h0);
    @(negedge clock);
    check_eq("ena_0101",    seg_all, {7'h7F, 7'h00, 7'h7F, 7'h00});
    check_eq("ena_0101_dp", dp_all,  4'hF);

    do_load(16'h8888, 4'hF, 4'b0101, 4'h0);
    @(negedge clock);
    check_eq("dp_disabled_dark", dp_all, 4'b1010);

    do_load(16'h3456, 4'h0, 4'hF, 4'h0);
    @(negedge clock);
    check_eq("glyph_3456", seg_all, {7'h30, 7'h19, 7'h12, 7'h02});
    do_load(16'h789B, 4'h0, 4'hF, 4'h0);
    @(negedge clock);
    check_eq("glyph_789B", seg_all, {7'h78, 7'h00, 7'h10, 7'h03});
    do_load(16'hCDE1, 4'h0, 4'hF, 4'h0);
    @(negedge clock);
    check_eq("glyph_CDE1", seg_all, {7'h46, 7'h21, 7'h06, 7'h79});

    value = 16'h1111; ena = 4'h0; dp = 4'hF;
    repeat (2) @(negedge clock);
    check_eq("no_load_ignored", seg_all, {7'h46, 7'h21, 7'h06, 7'h79});
    check_eq("no_load_dp",      dp_all,  4'hF);

    value = 16'h1111; dp = 4'h0; ena = 4'hF; blink = 4'h0; load = 1'b1;
    @(negedge clock);
    value = 16'hE000;
    @(negedge clock);
    load = 1'b0;
    @(negedge clock);
    check_eq("back_to_back", seg_all, {7'h06, 7'h40, 7'h40, 7'h40});

    do_load(16'h0040, 4'h0, 4'hF, 4'h0);
    @(negedge clock);
`ifdef HEX_DISPLAY_LZB_EN
    check_eq("lzb_0040", seg_all, {7'h7F, 7'h7F, 7'h19, 7'h40});
`else
    check_eq("lzb_0040", seg_all, {7'h40, 7'h40, 7'h19, 7'h40});
`endif
    do_load(16'h0000, 4'h0, 4'hF, 4'h0);
    @(negedge clock);
`ifdef HEX_DISPLAY_LZB_EN
    check_eq("lzb_0000", seg_all, {7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
    check_eq("lzb_0000", seg_all, {7'h40, 7'h40, 7'h40, 7'h40});
`endif
    do_load(16'h0000, 4'b0100, 4'hF, 4'h0);
    @(negedge clock);
`ifdef HEX_DISPLAY_LZB_EN
    check_eq("lzb_dp_stop", seg_all, {7'h7F, 7'h40, 7'h40, 7'h40});
`else
    check_eq("lzb_dp_stop", seg_all, {7'h40, 7'h40, 7'h40, 7'h40});
`endif
    check_eq("lzb_dp_stop_dp", dp_all, 4'b1011);

    do_load(16'h8888, 4'h0, 4'hF, 4'b0001);
    @(negedge clock);
    for (int i = 0; i < 16; i++) begin
      exp_seg = (((cyc - 1) % 8) >= 4) ? {7'h00, 7'h00, 7'h00, 7'h7F} : 28'h0;
      check_eq($sformatf("blink_c%0d", i), seg_all, exp_seg);
      @(negedge clock);
    end

    do_load(16'h12AF, 4'b0010, 4'hF, 4'h0);
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      if (((cyc - 1) % 4) == 0) begin
        exp_an   = 4'hF;
        exp_sseg = 8'hFF;
      end else begin
        exp_an   = an_tab[((cyc - 1) / 4) % 4];
        exp_sseg = sseg_tab[((cyc - 1) / 4) % 4];
      end
      check_eq($sformatf("scan_an_c%0d", i),  scan_an,  exp_an);
      check_eq($sformatf("scan_seg_c%0d", i), scan_seg, exp_sseg);
      @(negedge clock);
    end

    do_load(16'h5A5A, 4'hF, 4'hF, 4'h0);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_seg_all",  seg_all,  28'hFFFFFFF);
    check_eq("async_rst_dp_all",   dp_all,   4'hF);
    check_eq("async_rst_scan_seg", scan_seg, 8'hFF);
    check_eq("async_rst_scan_an",  scan_an,  4'hF);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check_eq($sformatf("post_rst_seg_c%0d", i),  seg_all,  28'hFFFFFFF);
      check_eq($sformatf("post_rst_scan_c%0d", i), scan_seg, 8'hFF);
    end
    check_eq("post_rst_dp_all", dp_all, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
